// File: rtl/bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter
//
// Sequential binary-to-BCD converter for the score / tile-value display path.
// Runs the shift-and-add-3 (double-dabble) algorithm one operand bit per clock,
// so the datapath stays the same size as BIN_WIDTH grows. A start/done
// handshake frames each conversion. The result is presented with a
// leading-zero blanking mask for the digit renderers and an overflow flag for
// operands that need more than DIGITS decimal digits.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   conversion request, honoured only in IDLE or DONE
//   binary    in   operand, latched when start is accepted
//   busy      out  high while the conversion is shifting
//   done      out  one-cycle pulse when a new result is presented
//   bcd       out  result, digit k in bits [4k+3:4k], digit 0 = ones
//   blank     out  leading-zero mask, bit k = 1 suppresses digit k
//   overflow  out  result did not fit in DIGITS digits (bcd = value mod 10^DIGITS)
// -----------------------------------------------------------------------------
module bcd_seq_converter #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  // Reset / idle display mask: every digit above the ones digit suppressed.
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0]    blank_q, blank_d;
  logic                 overflow_q, overflow_d;

  logic [BCD_W-1:0]     corr;
  logic [BCD_W-1:0]     scratch_shift;
  logic                 top_bit;
  logic                 ovf_next;
  logic                 last_shift;
  logic                 accept;
  logic [DIGITS-1:0]    blank_mask;
  logic                 zero_above;

  // ---------------------------------------------------------------------------
  // Double-dabble step: per-digit add-3 correction, then a 1-bit left shift of
  // {scratch, shift}. Digits never carry into each other; the corrected top
  // digit's bit 3 is the bit that falls off the end.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any conditional
  // assignment so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    corr = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) corr[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      else                             corr[4*k +: 4] = scratch_q[4*k +: 4];
    end
  end

  assign top_bit       = corr[BCD_W-1];
  assign scratch_shift = {corr[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
  assign ovf_next      = ovf_acc_q | top_bit;
  assign last_shift    = (count_q == CNT_W'(1));
  assign accept        = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Leading-zero mask of the value about to be published. Bit k is set when
  // digits k..DIGITS-1 are all zero; the ones digit is always shown, and an
  // overflowed (truncated) result is never blanked.
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (scratch_shift[4*k +: 4] == 4'd0);
      blank_mask[k] = zero_above;
    end
    if (ovf_next) blank_mask = '0;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic. start is ignored while shifting (not queued).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_shift) state_d = S_DONE;
      S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from the state register only, so no input reaches
  // an output combinationally.
  always_comb begin
    busy     = (state_q == S_SHIFT);
    done     = (state_q == S_DONE);
    bcd      = bcd_q;
    blank    = blank_q;
    overflow = overflow_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    ovf_acc_d  = ovf_acc_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;

    if (accept) begin
      shift_d   = binary;
      scratch_d = '0;
      count_d   = CNT_W'(BIN_WIDTH);
      ovf_acc_d = 1'b0;
    end else if (state_q == S_SHIFT) begin
      shift_d   = shift_q << 1;
      scratch_d = scratch_shift;
      count_d   = count_q - CNT_W'(1);
      ovf_acc_d = ovf_next;
      // Publish on the SHIFT -> DONE edge; results then hold until the next one.
      if (last_shift) begin
        bcd_d      = scratch_shift;
        overflow_d = ovf_next;
        blank_d    = blank_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      ovf_acc_q  <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= BLANK_RST;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      ovf_acc_q  <= ovf_acc_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
